// File: rtl/amp_filter_bank.sv
// Purpose : snapshot BIN_QTY note amplitudes on start, run slow/fast IIR per bin
//           (LANES bins per cycle), publish floor-clamped slow values, fast values,
//           their sum, and the peak bin.
// Latency : start sampled at edge 0 -> data_v high for one cycle after edge N+1
//           (N = BIN_QTY/LANES); a held start restarts every N+2 cycles.
// Backpressure: none; start is ignored while busy, outputs hold between frames.
// Ports   : clk/rst (sync, active-high), start, noteAmplitudes_i (BIN_QTY x W+D),
//           noteAmplitudes_o / noteAmplitudesFast_o (per bin), amplitudeSumNew_o,
//           amplitudeMax_o, maxIndex_o, busy, data_v.
module amp_filter_bank #(
  parameter int W          = 5,
  parameter int D          = 11,
  parameter int BIN_QTY    = 12,
  parameter int LANES      = 1,
  parameter int SLOW_SHIFT = 3,
  parameter int FAST_SHIFT = 1,
  parameter int LEDFloor   = 205
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [BIN_QTY-1:0][W+D-1:0]           noteAmplitudes_i,
  output logic [BIN_QTY-1:0][W+D-1:0]           noteAmplitudes_o,
  output logic [BIN_QTY-1:0][W+D-1:0]           noteAmplitudesFast_o,
  output logic [W+D+$clog2(BIN_QTY)-1:0]        amplitudeSumNew_o,
  output logic [W+D-1:0]                        amplitudeMax_o,
  output logic [$clog2(BIN_QTY)-1:0]            maxIndex_o,
  output logic                                  busy,
  output logic                                  data_v
);

  localparam int WD   = W + D;
  localparam int SW   = WD + 1;
  localparam int N    = BIN_QTY / LANES;
  localparam int GW   = (N > 1) ? $clog2(N) : 1;
  localparam int IW   = $clog2(BIN_QTY);
  localparam int SUMW = WD + IW;
  localparam logic [WD-1:0] FLOOR = WD'(LEDFloor);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  // One IIR update: s += (x - s) >>> sh, evaluated in WD+1 signed bits.
  // The result always lies between s and x, so the low WD bits are exact.
  function automatic logic [WD-1:0] iir_step(input logic [WD-1:0] s,
                                             input logic [WD-1:0] x,
                                             input int            sh);
    logic signed [SW-1:0] diff;
    logic signed [SW-1:0] nxt;
    diff = $signed({1'b0, x}) - $signed({1'b0, s});
    nxt  = $signed({1'b0, s}) + (diff >>> sh);
    return nxt[WD-1:0];
  endfunction

  function automatic logic [WD-1:0] floor_sub(input logic [WD-1:0] s);
    return (s > FLOOR) ? (s - FLOOR) : '0;
  endfunction

  state_t                       state_q, state_d;
  logic [GW-1:0]                g_q, g_d;
  logic [BIN_QTY-1:0][WD-1:0]   snap_q, snap_d;
  logic [BIN_QTY-1:0][WD-1:0]   slow_q, slow_d;
  logic [BIN_QTY-1:0][WD-1:0]   fast_q, fast_d;
  logic [SUMW-1:0]              acc_sum_q, acc_sum_d;
  logic [WD-1:0]                acc_max_q, acc_max_d;
  logic [IW-1:0]                acc_idx_q, acc_idx_d;
  logic [SUMW-1:0]              sum_out_q, sum_out_d;
  logic [WD-1:0]                max_out_q, max_out_d;
  logic [IW-1:0]                idx_out_q, idx_out_d;
  logic                         data_v_q, data_v_d;

  logic [IW-1:0]                bin_idx;
  logic [WD-1:0]                bin_out;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    snap_d    = snap_q;
    slow_d    = slow_q;
    fast_d    = fast_q;
    acc_sum_d = acc_sum_q;
    acc_max_d = acc_max_q;
    acc_idx_d = acc_idx_q;
    sum_out_d = sum_out_q;
    max_out_d = max_out_q;
    idx_out_d = idx_out_q;
    data_v_d  = 1'b0;
    bin_idx   = '0;
    bin_out   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PROC;
          snap_d    = noteAmplitudes_i;
          acc_sum_d = '0;
          acc_max_d = '0;
          acc_idx_d = '0;
          g_d       = '0;
        end
      end

      PROC: begin
        // Lanes are walked in ascending bin order so the strict compare keeps
        // the lowest index on ties, both within and across groups.
        for (int l = 0; l < LANES; l++) begin
          bin_idx         = IW'(int'(g_q) * LANES + l);
          fast_d[bin_idx] = iir_step(fast_q[bin_idx], snap_q[bin_idx], FAST_SHIFT);
          slow_d[bin_idx] = iir_step(slow_q[bin_idx], snap_q[bin_idx], SLOW_SHIFT);
          bin_out         = floor_sub(slow_d[bin_idx]);
          acc_sum_d       = acc_sum_d + SUMW'(bin_out);
          if (bin_out > acc_max_d) begin
            acc_max_d = bin_out;
            acc_idx_d = bin_idx;
          end
        end
        if (g_q == GW'(N - 1)) begin
          state_d = DONE;
        end else begin
          g_d = g_q + 1'b1;
        end
      end

      DONE: begin
        sum_out_d = acc_sum_q;
        max_out_d = acc_max_q;
        idx_out_d = acc_idx_q;
        data_v_d  = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      snap_q    <= '0;
      slow_q    <= '0;
      fast_q    <= '0;
      acc_sum_q <= '0;
      acc_max_q <= '0;
      acc_idx_q <= '0;
      sum_out_q <= '0;
      max_out_q <= '0;
      idx_out_q <= '0;
      data_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      snap_q    <= snap_d;
      slow_q    <= slow_d;
      fast_q    <= fast_d;
      acc_sum_q <= acc_sum_d;
      acc_max_q <= acc_max_d;
      acc_idx_q <= acc_idx_d;
      sum_out_q <= sum_out_d;
      max_out_q <= max_out_d;
      idx_out_q <= idx_out_d;
      data_v_q  <= data_v_d;
    end
  end

  // Published per-bin output is a pure function of the slow state, so it
  // tracks each bin as its group is processed and is zero straight out of reset.
  always_comb begin
    for (int i = 0; i < BIN_QTY; i++) begin
      noteAmplitudes_o[i] = floor_sub(slow_q[i]);
    end
  end

  assign noteAmplitudesFast_o = fast_q;
  assign amplitudeSumNew_o    = sum_out_q;
  assign amplitudeMax_o       = max_out_q;
  assign maxIndex_o           = idx_out_q;
  assign busy                 = (state_q != IDLE);
  assign data_v               = data_v_q;

endmodule

// File: tb/tb_amp_filter_bank.sv
module tb_amp_filter_bank;

  typedef logic [11:0][15:0] amp_t;

  typedef struct {
    amp_t ain;
    int   chk_bin;
    int   exp_fast;
    int   exp_out;
    int   exp_sum;
    int   exp_max;
    int   exp_idx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        start [3];
  amp_t        ain   [3];
  amp_t        aout  [3];
  amp_t        afast [3];
  logic [19:0] asum  [3];
  logic [15:0] amax  [3];
  logic [3:0]  aidx  [3];
  logic        busy  [3];
  logic        dv    [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instance 0: default parameters.
  amp_filter_bank u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .noteAmplitudes_i(ain[0]),
    .noteAmplitudes_o(aout[0]), .noteAmplitudesFast_o(afast[0]),
    .amplitudeSumNew_o(asum[0]), .amplitudeMax_o(amax[0]), .maxIndex_o(aidx[0]),
    .busy(busy[0]), .data_v(dv[0]));

  // Instance 1: four lanes.
  amp_filter_bank #(.LANES(4)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .noteAmplitudes_i(ain[1]),
    .noteAmplitudes_o(aout[1]), .noteAmplitudesFast_o(afast[1]),
    .amplitudeSumNew_o(asum[1]), .amplitudeMax_o(amax[1]), .maxIndex_o(aidx[1]),
    .busy(busy[1]), .data_v(dv[1]));

  // Instance 2: slow filter passes the input straight through.
  amp_filter_bank #(.SLOW_SHIFT(0)) u_dut2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .noteAmplitudes_i(ain[2]),
    .noteAmplitudes_o(aout[2]), .noteAmplitudesFast_o(afast[2]),
    .amplitudeSumNew_o(asum[2]), .amplitudeMax_o(amax[2]), .maxIndex_o(aidx[2]),
    .busy(busy[2]), .data_v(dv[2]));

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic amp_t mk(input logic [11:0] mask, input logic [15:0] val);
    amp_t r;
    r = '0;
    for (int i = 0; i < 12; i++) if (mask[i]) r[i] = val;
    return r;
  endfunction

  // One frame on instance k; inputs are scrambled right after the capture edge.
  // lat = cycles from the start-sampling edge to data_v, or -1 on timeout.
  task automatic run_frame(input int k, input amp_t v, output int lat);
    @(negedge clk);
    ain[k]   = v;
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    for (int i = 0; i < 12; i++) ain[k][i] = 16'($urandom);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (dv[k]) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  vec_t tv[5];
  int   lat;
  int   np;
  int   tp[3];
  int   cyc;
  int   tlast;

  initial begin
    tv[0] = '{mk(12'h00F, 16'hFFFF), 0, 32767,  7986, 31944,  7986, 0};
    tv[1] = '{mk(12'h00F, 16'hFFFF), 0, 49151, 15154, 60616, 15154, 0};
    tv[2] = '{mk(12'h000, 16'h0000), 0, 24575, 13234, 52936, 13234, 0};
    tv[3] = '{mk(12'h080, 16'hFFFF), 7, 32767,  7986, 54202, 11554, 0};
    tv[4] = '{mk(12'h280, 16'hFFFF), 9, 32767,  7986, 63476, 15154, 7};

    // Reset with start asserted at the same time: nothing may happen.
    for (int k = 0; k < 3; k++) begin
      rst[k]   = 1'b1;
      start[k] = 1'b1;
      ain[k]   = mk(12'hFFF, 16'hFFFF);
    end
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_out", k),  longint'(aout[k] == '0), 1);
      chk($sformatf("rst%0d_fast", k), longint'(afast[k] == '0), 1);
      chk($sformatf("rst%0d_sum", k),  longint'(asum[k]), 0);
      chk($sformatf("rst%0d_max", k),  longint'(amax[k]), 0);
      chk($sformatf("rst%0d_idx", k),  longint'(aidx[k]), 0);
      chk($sformatf("rst%0d_busy", k), longint'(busy[k]), 0);
      chk($sformatf("rst%0d_dv", k),   longint'(dv[k]), 0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rst[k]   = 1'b0;
      start[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_busy", longint'(busy[0]), 0);
    chk("post_rst_fast", longint'(afast[0] == '0), 1);

    // Table-driven frames on the default instance; filter state carries over.
    for (int i = 0; i < 5; i++) begin
      run_frame(0, tv[i].ain, lat);
      chk($sformatf("v%0d_latency", i), lat, 13);
      chk($sformatf("v%0d_fast", i), longint'(afast[0][tv[i].chk_bin]), tv[i].exp_fast);
      chk($sformatf("v%0d_out", i),  longint'(aout[0][tv[i].chk_bin]), tv[i].exp_out);
      chk($sformatf("v%0d_out11", i), longint'(aout[0][11]), 0);
      chk($sformatf("v%0d_sum", i),  longint'(asum[0]), tv[i].exp_sum);
      chk($sformatf("v%0d_max", i),  longint'(amax[0]), tv[i].exp_max);
      chk($sformatf("v%0d_idx", i),  longint'(aidx[0]), tv[i].exp_idx);
      chk($sformatf("v%0d_busy", i), longint'(busy[0]), 0);
    end

    // Held start: data_v every N+2 = 14 cycles.
    @(negedge clk);
    ain[0]   = '0;
    start[0] = 1'b1;
    np  = 0;
    cyc = 0;
    while (np < 3 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dv[0]) begin
        tp[np] = cyc;
        np++;
      end
    end
    @(negedge clk);
    start[0] = 1'b0;
    chk("held_pulses", np, 3);
    if (np == 3) begin
      chk("held_gap1", tp[1] - tp[0], 14);
      chk("held_gap2", tp[2] - tp[1], 14);
    end
    cyc = 0;
    while (busy[0] && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("held_drain_idle", longint'(busy[0]), 0);

    // Toggling start while busy must not add frames.
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    np    = 0;
    tlast = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start[0] = (c <= 12) ? ((c % 2) == 1) : 1'b0;
      @(posedge clk);
      #1;
      if (dv[0]) begin
        np++;
        tlast = c;
      end
    end
    chk("toggle_pulses", np, 1);
    chk("toggle_latency", tlast, 13);

    // Four lanes: tie between bins 5 and 9 goes to bin 5.
    run_frame(1, mk(12'h220, 16'h0800), lat);
    chk("l4_latency", lat, 4);
    chk("l4_out5", longint'(aout[1][5]), 51);
    chk("l4_out9", longint'(aout[1][9]), 51);
    chk("l4_fast5", longint'(afast[1][5]), 1024);
    chk("l4_sum", longint'(asum[1]), 102);
    chk("l4_max", longint'(amax[1]), 51);
    chk("l4_idx", longint'(aidx[1]), 5);

    // Everything below the floor.
    run_frame(2, mk(12'hFFF, 16'd100), lat);
    chk("flr_latency", lat, 13);
    chk("flr_out_zero", longint'(aout[2] == '0), 1);
    chk("flr_sum", longint'(asum[2]), 0);
    chk("flr_max", longint'(amax[2]), 0);
    chk("flr_idx", longint'(aidx[2]), 0);
    chk("flr_fast0", longint'(afast[2][0]), 50);

    // Reset in the middle of a frame aborts it and clears the filters.
    @(negedge clk);
    ain[2]   = mk(12'hFFF, 16'd100);
    start[2] = 1'b1;
    @(posedge clk);
    #1;
    start[2] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy_before", longint'(busy[2]), 1);
    chk("abort_fast4_before", longint'(afast[2][4]), 75);
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    np = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (dv[2]) np++;
    end
    chk("abort_no_dv", np, 0);
    chk("abort_fast_zero", longint'(afast[2] == '0), 1);
    chk("abort_busy", longint'(busy[2]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
